// File: rtl/ddr4_v2_2_20_axi_ctrl_wr_chan.sv
`default_nettype none
// ============================================================================
//  Module      : ddr4_v2_2_20_axi_ctrl_wr_chan
//  Description : AXI4-Lite write channel for the DDR4 controller register
//                bank. Takes one AW/W pair at a time, decodes the address
//                against a register address table and issues a single-cycle
//                one-hot write strobe. The B response reports SLVERR for an
//                unmapped or read-only register.
//                Optional feature: define DDR4_AXI_CTRL_WSTRB_EN to honour
//                wstrb with a read-modify-write byte merge.
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr4_v2_2_20_axi_ctrl_wr_chan #(
    parameter int                          C_ADDR_WIDTH     = 32,
    parameter int                          C_DATA_WIDTH     = 32,
    parameter int                          C_NUM_REG        = 5,
    parameter int                          C_NUM_REG_WIDTH  = 3,
    parameter logic [32*C_NUM_REG-1:0]     C_REG_ADDR_ARRAY =
        160'h0000_f00C_0000_f008_0000_f004_0000_f000_FFFF_FFFF,
    parameter logic [C_NUM_REG-1:0]        C_REG_WRAC_ARRAY = 5'b11110
) (
    input  logic                              clk,
    input  logic                              reset,
    // write address channel
    input  logic                              awvalid,
    output logic                              awready,
    input  logic [C_ADDR_WIDTH-1:0]           awaddr,
    // write data channel
    input  logic                              wvalid,
    output logic                              wready,
    input  logic [C_DATA_WIDTH-1:0]           wdata,
    input  logic [C_DATA_WIDTH/8-1:0]         wstrb,
    // write response channel
    output logic                              bvalid,
    input  logic                              bready,
    output logic [1:0]                        bresp,
    // register bank interface
    input  logic [C_DATA_WIDTH*C_NUM_REG-1:0] reg_bank_array,
    output logic [C_NUM_REG-1:0]              reg_wr_en,
    output logic [C_DATA_WIDTH-1:0]           reg_wr_data
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WAIT_W  = 3'd1;
    localparam logic [2:0] WAIT_AW = 3'd2;
    localparam logic [2:0] WRITE   = 3'd3;
    localparam logic [2:0] RESP    = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [2:0]                 state;
    logic [2:0]                 state_nxt;
    logic                       aw_hs;
    logic                       w_hs;
    logic                       b_hs;
    logic [C_ADDR_WIDTH-1:0]    addr_q;
    logic [C_DATA_WIDTH-1:0]    data_q;
    logic [C_NUM_REG_WIDTH-1:0] idx;
    logic                       allowed;
    logic                       do_write;
    logic [C_DATA_WIDTH-1:0]    write_value;

    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;
    assign b_hs  = bvalid & bready;

    // Next-state selection; AW and W may arrive together or in either order.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (aw_hs && w_hs) begin
                    state_nxt = WRITE;
                end else if (aw_hs) begin
                    state_nxt = WAIT_W;
                end else if (w_hs) begin
                    state_nxt = WAIT_AW;
                end
            end
            WAIT_W:  if (w_hs)  state_nxt = WRITE;
            WAIT_AW: if (aw_hs) state_nxt = WRITE;
            WRITE:   state_nxt = RESP;
            RESP:    if (b_hs)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, registered ready flags (derived from the upcoming state) and B channel.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
        end else begin
            state   <= state_nxt;
            awready <= (state_nxt == IDLE) || (state_nxt == WAIT_AW);
            wready  <= (state_nxt == IDLE) || (state_nxt == WAIT_W);
            if (state == WRITE) begin
                bvalid <= 1'b1;
                bresp  <= allowed ? RESP_OKAY : RESP_SLVERR;
            end else if (b_hs) begin
                bvalid <= 1'b0;
                bresp  <= RESP_OKAY;
            end
        end
    end

`ifdef DDR4_AXI_CTRL_WSTRB_EN
    logic [C_DATA_WIDTH/8-1:0] strb_q;
    logic [C_DATA_WIDTH-1:0]   byte_mask;
    logic [C_DATA_WIDTH-1:0]   old_value;

    // Capture address, data and strobes on their handshakes; held until the next transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            data_q <= '0;
            strb_q <= '0;
        end else begin
            if (aw_hs) addr_q <= awaddr;
            if (w_hs) begin
                data_q <= wdata;
                strb_q <= wstrb;
            end
        end
    end

    for (genvar b = 0; b < C_DATA_WIDTH/8; b++) begin : g_byte_mask
        assign byte_mask[8*b +: 8] = {8{strb_q[b]}};
    end

    assign old_value   = reg_bank_array[C_DATA_WIDTH*idx +: C_DATA_WIDTH];
    assign write_value = (old_value & ~byte_mask) | (data_q & byte_mask);
    // An all-zero wstrb is a legal no-op write: no strobe, but still OKAY.
    assign do_write    = (state == WRITE) && allowed && (|strb_q);
`else
    logic unused_inputs;

    // Capture address and data on their handshakes; held until the next transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            data_q <= '0;
        end else begin
            if (aw_hs) addr_q <= awaddr;
            if (w_hs)  data_q <= wdata;
        end
    end

    // Full-word writes only: strobes and current register values are not needed.
    assign unused_inputs = &{1'b0, wstrb, reg_bank_array};
    assign write_value   = data_q;
    assign do_write      = (state == WRITE) && allowed;
`endif

    // Address decode: lowest matching entry at index 1 or above; 0 means no match.
    always_comb begin
        idx = '0;
        for (int i = 1; i < C_NUM_REG; i++) begin
            if ((idx == '0) &&
                (addr_q == C_ADDR_WIDTH'(C_REG_ADDR_ARRAY[32*i +: 32]))) begin
                idx = C_NUM_REG_WIDTH'(i);
            end
        end
    end

    assign allowed = (idx != '0) && C_REG_WRAC_ARRAY[idx];

    // Single-cycle one-hot strobe in WRITE; data bus is zero whenever no strobe fires.
    always_comb begin
        reg_wr_en   = '0;
        reg_wr_data = '0;
        if (do_write) begin
            reg_wr_en   = C_NUM_REG'(1) << idx;
            reg_wr_data = write_value;
        end
    end

endmodule
`default_nettype wire

// File: doc/ddr4_v2_2_20_axi_ctrl_wr_chan.md
DDR4_V2_2_20_AXI_CTRL_WR_CHAN -- requirements
Module: ddr4_v2_2_20_axi_ctrl_wr_chan

Interface
REQ-001 SHALL have parameter C_ADDR_WIDTH, default 32, AXI4-Lite address width.
REQ-002 SHALL have parameter C_DATA_WIDTH, default 32, data width; only 32 is supported.
REQ-003 SHALL have parameter C_NUM_REG, default 5, register count, where entry 0 is the no-match slot.
REQ-004 SHALL have parameter C_NUM_REG_WIDTH, default 3, register index width.
REQ-005 SHALL have parameter C_REG_ADDR_ARRAY, default 160'h0000_f00C_0000_f008_0000_f004_0000_f000_FFFF_FFFF, giving the address of entry i at bits [32*i+:32].
REQ-006 SHALL have parameter C_REG_WRAC_ARRAY, default 5'b11110, where bit i=1 means entry i is writable.
REQ-007 SHALL have ports clk (in, 1, clock) and reset (in, 1, reset); one clock; reset is synchronous and active-high.
REQ-008 SHALL have ports awvalid (in, 1), awready (out, 1) and awaddr (in, C_ADDR_WIDTH) for the write-address channel.
REQ-009 SHALL have ports wvalid (in, 1), wready (out, 1), wdata (in, C_DATA_WIDTH) and wstrb (in, C_DATA_WIDTH/8) for the write-data channel.
REQ-010 SHALL have ports bvalid (out, 1), bready (in, 1) and bresp (out, 2) for the write-response channel.
REQ-011 SHALL have port reg_bank_array (in, C_DATA_WIDTH*C_NUM_REG), carrying current register values.
REQ-012 SHALL have port reg_wr_en (out, C_NUM_REG), a one-hot write strobe.
REQ-013 SHALL have port reg_wr_data (out, C_DATA_WIDTH), the data to write.

Function
REQ-014 SHALL implement states IDLE, WAIT_W, WAIT_AW, WRITE and RESP.
REQ-015 SHALL assert awready only in IDLE and WAIT_AW, and wready only in IDLE and WAIT_W; both are registered outputs.
REQ-016 IDLE transitions:
- AW and W both handshake -> WRITE
- AW only -> WAIT_W
- W only -> WAIT_AW
REQ-017 WAIT_W SHALL go to WRITE on the W handshake; WAIT_AW SHALL go to WRITE on the AW handshake.
REQ-018 SHALL capture awaddr, wdata and wstrb on their respective handshakes and hold them until RESP exits.
REQ-019 SHALL decode the captured address to the lowest index i>=1 whose address equals it; if none matches, the index is 0.
REQ-020 In WRITE, for exactly one cycle, SHALL assert reg_wr_en[i] when the index i>=1 and C_REG_WRAC_ARRAY[i]=1; otherwise reg_wr_en SHALL stay all-zero.
REQ-021 SHALL go from WRITE to RESP the next cycle, with bvalid=1.
REQ-022 bresp SHALL be 2'b00 when the write is allowed and 2'b10 (SLVERR) when the index is 0 or the register is not writable.
REQ-023 SHALL hold bvalid and bresp stable until bready=1; on the handshake cycle it goes to IDLE, and bvalid drops the next cycle.
REQ-024 Minimum latency: the AW+W handshake at cycle N gives the strobe at N+1 and bvalid at N+2.
REQ-025 SHALL accept no new AW or W while in WRITE or RESP, so at most one transaction is outstanding.
REQ-026 SHALL set reg_wr_data to zero whenever reg_wr_en is all-zero.

Reset
REQ-027 While reset=1, SHALL force state=IDLE, awready=0, wready=0, bvalid=0, bresp=2'b00, reg_wr_en=0 and reg_wr_data=0.
REQ-028 SHALL set awready=wready=1 on the first cycle after reset deasserts.
REQ-029 Reset asserted in WAIT_W, WAIT_AW, WRITE or RESP SHALL abort the transaction: no strobe and no response, and captured data is discarded.

Configuration
REQ-030 Macro DDR4_AXI_CTRL_WSTRB_EN.
- Defined: reg_wr_data = (old & ~mask) | (wdata & mask), where old is the selected register's value in reg_bank_array and mask expands wstrb per byte. wstrb=0 SHALL suppress the strobe but still respond OKAY.
- Undefined: wstrb is ignored, reg_wr_data = wdata, and a full-word write is always performed.

Verification
REQ-031 Simultaneous AW=0xf004 and W=0xA5A5A5A5 at cycle N, with bready held 1 -> reg_wr_en=5'b00100 at N+1, bvalid=1 and bresp=00 at N+2, state IDLE at N+3.
REQ-032 W=0x12345678 first, then AW=0xf00C three cycles later -> strobe reg_wr_en=5'b10000 with data 0x12345678; awready stays 0 through RESP.
REQ-033 AW=0xDEAD0000 -> no strobe and bresp=2'b10; with C_REG_WRAC_ARRAY=5'b11010 and AW=0xf004 -> no strobe and bresp=2'b10.
REQ-034 bready held 0 for 5 cycles after bvalid -> bvalid and bresp stable; a second AW is not accepted until the B handshake.
REQ-035 Reset pulsed in WAIT_W -> no strobe and no bvalid; awready=wready=1 the cycle after reset deasserts.
REQ-036 With DDR4_AXI_CTRL_WSTRB_EN defined, old=0x11223344, wdata=0xAABBCCDD, wstrb=4'b0101 -> reg_wr_data=0x11BB33DD; undefined -> 0xAABBCCDD.
